// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multi-cycle accumulator controller:
// opcodes, function bits, ALU codes, mux selects and FSM states.
package mc_controller_pkg;

    localparam int OP_W = 4;
    localparam int FN_W = 9;

    localparam logic [OP_W-1:0] OP_LOAD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_STORE = 4'b0001;
    localparam logic [OP_W-1:0] OP_JUMP  = 4'b0010;
    localparam logic [OP_W-1:0] OP_BRZ   = 4'b0100;
    localparam logic [OP_W-1:0] OP_TYPEC = 4'b1000;

    localparam int FN_MOVETO   = 0;
    localparam int FN_MOVEFROM = 1;
    localparam int FN_ADD      = 2;
    localparam int FN_SUB      = 3;
    localparam int FN_AND      = 4;
    localparam int FN_OR       = 5;
    localparam int FN_NOT      = 6;
    localparam int FN_NOP      = 7;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_NOTB  = 3'b100;
    localparam logic [2:0] ALU_PASSB = 3'b101;
    localparam logic [2:0] ALU_PASSA = 3'b110;

    localparam logic [1:0] PC_ALU  = 2'b00;
    localparam logic [1:0] PC_IMM  = 2'b01;
    localparam logic [1:0] PC_PAGE = 2'b10;

    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_LD_MEM = 4'd2,
        S_LD_WB  = 4'd3,
        S_ST_MEM = 4'd4,
        S_JMP    = 4'd5,
        S_BRZ    = 4'd6,
        S_C_EX   = 4'd7,
        S_C_WB   = 4'd8,
        S_I_EX   = 4'd9,
        S_I_WB   = 4'd10
    } state_e;

    // Exactly one of the seven real operations selected; NOP or bit 8 alone is not.
    function automatic logic fn_legal(input logic [FN_W-1:0] fn);
        return ($countones(fn) == 1) && (fn[FN_NOT:FN_MOVETO] != '0);
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: decoded IR fields and zero flag in,
// strobes and mux selects out.
interface mc_controller_if;
    import mc_controller_pkg::*;

    logic [OP_W-1:0] op;
    logic [FN_W-1:0] fn;
    logic            zero;
    logic            mem_read;
    logic            mem_write;
    logic            IorD;
    logic            IRWrite;
    logic            writeRegSel;
    logic            MemToReg;
    logic            writeRegEn;
    logic            PCld;
    logic [1:0]      PCSrc;
    logic [2:0]      ALU_control;
    logic            ALUSrcA;
    logic [1:0]      ALUSrcB;
    logic [3:0]      state;

    modport master (
        input  op, fn, zero,
        output mem_read, mem_write, IorD, IRWrite, writeRegSel,
        output MemToReg, writeRegEn, PCld, PCSrc, ALU_control,
        output ALUSrcA, ALUSrcB, state
    );

    modport slave (
        output op, fn, zero,
        input  mem_read, mem_write, IorD, IRWrite, writeRegSel,
        input  MemToReg, writeRegEn, PCld, PCSrc, ALU_control,
        input  ALUSrcA, ALUSrcB, state
    );

endinterface

// File: rtl/mc_controller_alu_decoder.sv
// ALU operation select from FSM state, opcode and type-C function,
// plus the type-C NOP flag.
module mc_controller_alu_decoder
    import mc_controller_pkg::*;
(
    input  state_e          state_i,
    input  logic [OP_W-1:0] op_i,
    input  logic [FN_W-1:0] fn_i,
    output logic [2:0]      alu_ctrl_o,
    output logic            fn_nop_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        fn_nop_o   = !fn_legal(fn_i);
        case (state_i)
            S_BRZ: alu_ctrl_o = ALU_PASSA;
            S_I_EX: alu_ctrl_o = {1'b0, op_i[1:0]};
            S_C_EX: begin
                if (!fn_nop_o) begin
                    unique case (1'b1)
                        fn_i[FN_MOVETO]:   alu_ctrl_o = ALU_PASSA;
                        fn_i[FN_MOVEFROM]: alu_ctrl_o = ALU_PASSB;
                        fn_i[FN_ADD]:      alu_ctrl_o = ALU_ADD;
                        fn_i[FN_SUB]:      alu_ctrl_o = ALU_SUB;
                        fn_i[FN_AND]:      alu_ctrl_o = ALU_AND;
                        fn_i[FN_OR]:       alu_ctrl_o = ALU_OR;
                        fn_i[FN_NOT]:      alu_ctrl_o = ALU_NOTB;
                        default:           alu_ctrl_o = ALU_ADD;
                    endcase
                end
            end
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle fetch/decode/execute FSM for the 16-bit accumulator datapath.
// Moore outputs, except PCld in BRZ which follows the live zero flag.
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mc_controller_if.master bus
);

    state_e     state_q;
    state_e     state_d;
    logic [2:0] alu_ctrl;
    logic       fn_nop;

    mc_controller_alu_decoder u_alu_dec (
        .state_i    (state_q),
        .op_i       (bus.op),
        .fn_i       (bus.fn),
        .alu_ctrl_o (alu_ctrl),
        .fn_nop_o   (fn_nop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                if (bus.op[3:2] == 2'b11) begin
                    state_d = S_I_EX;
                end else begin
                    case (bus.op)
                        OP_LOAD:  state_d = S_LD_MEM;
                        OP_STORE: state_d = S_ST_MEM;
                        OP_JUMP:  state_d = S_JMP;
                        OP_BRZ:   state_d = S_BRZ;
                        OP_TYPEC: state_d = S_C_EX;
                        default:  state_d = S_IF;
                    endcase
                end
            end
            S_LD_MEM: state_d = S_LD_WB;
            S_C_EX:   state_d = S_C_WB;
            S_I_EX:   state_d = S_I_WB;
            default:  state_d = S_IF;
        endcase
    end

    // Everything held low while in reset so no PC/IR/reg/mem update leaks out.
    always_comb begin
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.IorD        = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.writeRegSel = 1'b0;
        bus.MemToReg    = 1'b0;
        bus.writeRegEn  = 1'b0;
        bus.PCld        = 1'b0;
        bus.PCSrc       = PC_ALU;
        bus.ALU_control = ALU_ADD;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = SRCB_B;
        bus.state       = 4'd0;
        if (!rst) begin
            bus.state       = state_q;
            bus.ALU_control = alu_ctrl;
            case (state_q)
                S_IF: begin
                    bus.mem_read = 1'b1;
                    bus.IRWrite  = 1'b1;
                    bus.ALUSrcB  = SRCB_ONE;
                    bus.PCld     = 1'b1;
                end
                S_LD_MEM: begin
                    bus.mem_read = 1'b1;
                    bus.IorD     = 1'b1;
                end
                S_LD_WB: begin
                    bus.MemToReg   = 1'b1;
                    bus.writeRegEn = 1'b1;
                end
                S_ST_MEM: begin
                    bus.mem_write = 1'b1;
                    bus.IorD      = 1'b1;
                end
                S_JMP: begin
                    bus.PCSrc = PC_IMM;
                    bus.PCld  = 1'b1;
                end
                S_BRZ: begin
                    bus.ALUSrcA = 1'b1;
                    bus.PCSrc   = PC_PAGE;
                    bus.PCld    = bus.zero;
                end
                S_C_EX: bus.ALUSrcA = 1'b1;
                S_C_WB: begin
                    bus.writeRegSel = bus.fn[FN_MOVETO];
                    bus.writeRegEn  = !fn_nop;
                end
                S_I_EX: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = SRCB_IMM;
                end
                S_I_WB: bus.writeRegEn = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
